// File: rtl/riscv_rob_pkg.sv
// Shared reorder-buffer definitions used by the ROB controller, scoreboard and ROB data array.
package riscv_rob_pkg;

  localparam int unsigned ROB_ENTRIES = 32;
  localparam int unsigned ROB_SLOT_W  = 5;

  // Per-slot lifecycle: allocated at issue, completed at writeback, freed at retirement.
  typedef enum logic [1:0] {
    EntFree    = 2'd0,
    EntPending = 2'd1,
    EntReady   = 2'd2
  } rob_state_e;

endpackage

// File: rtl/rob_entry_state.sv
// One ROB slot: lifecycle state plus the destination fields captured at allocation.
module rob_entry_state
  import riscv_rob_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic             alloc_wen,
  input  logic [REG_W-1:0] alloc_dst,
  input  logic             fill,
  input  logic             commit,
  output rob_state_e       state,
  output logic             wen,
  output logic [REG_W-1:0] dst,
  output logic             fill_bad
);

  // A completion is only meaningful for a slot that is still waiting on its result.
  always_comb begin
    fill_bad = fill && (state != EntPending);
  end

  // Slot state machine; alloc and commit never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EntFree;
      wen   <= 1'b0;
      dst   <= '0;
    end else if (alloc) begin
      state <= EntPending;
      wen   <= alloc_wen;
      dst   <= alloc_dst;
    end else if (fill && state == EntPending) begin
      state <= EntReady;
    end else if (commit) begin
      state <= EntFree;
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB slot allocation and dual retirement for the dual-issue core.
module rob_commit_ctrl
  import riscv_rob_pkg::*;
#(
  parameter int unsigned ENTRIES = ROB_ENTRIES,
  parameter int unsigned SLOT_W  = ROB_SLOT_W,
  parameter int unsigned REG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc0_val,
  input  logic              alloc0_wen,
  input  logic [REG_W-1:0]  alloc0_dst,
  input  logic              alloc1_val,
  input  logic              alloc1_wen,
  input  logic [REG_W-1:0]  alloc1_dst,
  output logic [SLOT_W-1:0] alloc0_slot,
  output logic [SLOT_W-1:0] alloc1_slot,
  output logic              rob_rdy_1,
  output logic              rob_rdy_2,
  input  logic              fillA_val,
  input  logic [SLOT_W-1:0] fillA_slot,
  input  logic              fillB_val,
  input  logic [SLOT_W-1:0] fillB_slot,
  output logic              commit_val_1,
  output logic [SLOT_W-1:0] commit_slot_1,
  output logic              commit_wen_1,
  output logic [REG_W-1:0]  commit_waddr_1,
  output logic              commit_val_2,
  output logic [SLOT_W-1:0] commit_slot_2,
  output logic              commit_wen_2,
  output logic [REG_W-1:0]  commit_waddr_2,
  output logic [SLOT_W:0]   occupancy,
  output logic              fill_err
);

  localparam int unsigned OccW = SLOT_W + 1;
  localparam logic [OccW-1:0] OccRdy1 = OccW'(ENTRIES - 1);
  localparam logic [OccW-1:0] OccRdy2 = OccW'(ENTRIES - 2);

  logic [SLOT_W-1:0] head_q, head_d, head_nxt, tail_q, tail_d;
  logic [OccW-1:0]   occ_q, occ_d, n_alloc, n_commit;
  logic              fill_err_q, fill_err_d;

  logic              alloc_ok, alloc0_go, alloc1_go;
  logic              fill_collide, fillA_go, fillB_go, fill_bad_any;
  logic              cv1, cv2;

  rob_state_e        ent_state     [ENTRIES];
  logic              ent_wen       [ENTRIES];
  logic [REG_W-1:0]  ent_dst       [ENTRIES];
  logic              ent_fill_bad  [ENTRIES];
  logic              ent_alloc     [ENTRIES];
  logic              ent_alloc0    [ENTRIES];
  logic              ent_alloc_wen [ENTRIES];
  logic [REG_W-1:0]  ent_alloc_dst [ENTRIES];
  logic              ent_fill      [ENTRIES];
  logic              ent_commit    [ENTRIES];

  // Readiness and slot grants; rdy uses pre-update occupancy so same-cycle frees are not reused.
  always_comb begin
    rob_rdy_1   = (occ_q <= OccRdy1);
    rob_rdy_2   = (occ_q <= OccRdy2);
    alloc0_slot = tail_q;
    alloc1_slot = alloc0_val ? tail_q + SLOT_W'(1) : tail_q;
    alloc_ok    = (alloc0_val && alloc1_val) ? rob_rdy_2 : rob_rdy_1;
    alloc0_go   = alloc0_val && alloc_ok;
    alloc1_go   = alloc1_val && alloc_ok;
  end

  // Writeback qualification; both pipes naming one slot is dropped entirely.
  always_comb begin
    fill_collide = fillA_val && fillB_val && (fillA_slot == fillB_slot);
    fillA_go     = fillA_val && !fill_collide;
    fillB_go     = fillB_val && !fill_collide;
  end

  // Retirement of the oldest one or two ready entries; nothing retires while in reset.
  always_comb begin
    head_nxt = head_q + SLOT_W'(1);
    cv1      = !reset && (ent_state[head_q] == EntReady);
    cv2      = cv1 && (occ_q >= OccW'(2)) && (ent_state[head_nxt] == EntReady);

    commit_val_1   = cv1;
    commit_slot_1  = cv1 ? head_q : '0;
    commit_wen_1   = cv1 && ent_wen[head_q];
    commit_waddr_1 = cv1 ? ent_dst[head_q] : '0;
    commit_val_2   = cv2;
    commit_slot_2  = cv2 ? head_nxt : '0;
    commit_wen_2   = cv2 && ent_wen[head_nxt];
    commit_waddr_2 = cv2 ? ent_dst[head_nxt] : '0;
  end

  // Decode pointers and strobes into per-slot alloc/fill/commit controls.
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ent_alloc0[i]    = alloc0_go && (alloc0_slot == SLOT_W'(i));
      ent_alloc[i]     = ent_alloc0[i] || (alloc1_go && (alloc1_slot == SLOT_W'(i)));
      ent_alloc_wen[i] = ent_alloc0[i] ? alloc0_wen : alloc1_wen;
      ent_alloc_dst[i] = ent_alloc0[i] ? alloc0_dst : alloc1_dst;
      ent_fill[i]      = (fillA_go && (fillA_slot == SLOT_W'(i)))
                      || (fillB_go && (fillB_slot == SLOT_W'(i)));
      ent_commit[i]    = (cv1 && (head_q == SLOT_W'(i))) || (cv2 && (head_nxt == SLOT_W'(i)));
    end
  end

  // Any slot receiving a completion it was not waiting for.
  always_comb begin
    fill_bad_any = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      fill_bad_any = fill_bad_any | ent_fill_bad[i];
    end
  end

  // Pointer, occupancy and sticky-error next state.
  always_comb begin
    n_alloc    = OccW'(alloc0_go) + OccW'(alloc1_go);
    n_commit   = OccW'(cv1) + OccW'(cv2);
    occ_d      = occ_q + n_alloc - n_commit;
    tail_d     = tail_q + SLOT_W'(n_alloc);
    head_d     = head_q + SLOT_W'(n_commit);
    fill_err_d = fill_err_q | fill_collide | fill_bad_any;
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      fill_err_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      fill_err_q <= fill_err_d;
    end
  end

  assign occupancy = occ_q;
  assign fill_err  = fill_err_q;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    rob_entry_state #(
      .REG_W(REG_W)
    ) u_ent (
      .clk      (clk),
      .reset    (reset),
      .alloc    (ent_alloc[g]),
      .alloc_wen(ent_alloc_wen[g]),
      .alloc_dst(ent_alloc_dst[g]),
      .fill     (ent_fill[g]),
      .commit   (ent_commit[g]),
      .state    (ent_state[g]),
      .wen      (ent_wen[g]),
      .dst      (ent_dst[g]),
      .fill_bad (ent_fill_bad[g])
    );
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for the ROB allocation / retirement controller.
module tb_rob_commit_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc0_val, alloc0_wen, alloc1_val, alloc1_wen;
  logic [4:0] alloc0_dst, alloc1_dst, alloc0_slot, alloc1_slot;
  logic       rob_rdy_1, rob_rdy_2;
  logic       fillA_val, fillB_val;
  logic [4:0] fillA_slot, fillB_slot;
  logic       commit_val_1, commit_wen_1, commit_val_2, commit_wen_2;
  logic [4:0] commit_slot_1, commit_waddr_1, commit_slot_2, commit_waddr_2;
  logic [5:0] occupancy;
  logic       fill_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rob_commit_ctrl dut (
    .clk(clk), .reset(reset),
    .alloc0_val(alloc0_val), .alloc0_wen(alloc0_wen), .alloc0_dst(alloc0_dst),
    .alloc1_val(alloc1_val), .alloc1_wen(alloc1_wen), .alloc1_dst(alloc1_dst),
    .alloc0_slot(alloc0_slot), .alloc1_slot(alloc1_slot),
    .rob_rdy_1(rob_rdy_1), .rob_rdy_2(rob_rdy_2),
    .fillA_val(fillA_val), .fillA_slot(fillA_slot),
    .fillB_val(fillB_val), .fillB_slot(fillB_slot),
    .commit_val_1(commit_val_1), .commit_slot_1(commit_slot_1),
    .commit_wen_1(commit_wen_1), .commit_waddr_1(commit_waddr_1),
    .commit_val_2(commit_val_2), .commit_slot_2(commit_slot_2),
    .commit_wen_2(commit_wen_2), .commit_waddr_2(commit_waddr_2),
    .occupancy(occupancy), .fill_err(fill_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alloc0_val = 0; alloc0_wen = 0; alloc0_dst = '0;
    alloc1_val = 0; alloc1_wen = 0; alloc1_dst = '0;
    fillA_val = 0; fillA_slot = '0; fillB_val = 0; fillB_slot = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    set_idle();
    step();
    reset = 0;
  endtask

  task automatic dual_alloc(input logic [4:0] d0, input logic [4:0] d1);
    set_idle();
    alloc0_val = 1; alloc0_wen = 1; alloc0_dst = d0;
    alloc1_val = 1; alloc1_wen = 1; alloc1_dst = d1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    total++; if (occupancy !== 6'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
    total++; if (rob_rdy_1 !== 1'b1 || rob_rdy_2 !== 1'b1) begin
      bad++; $display("FAIL reset_rdy got=%b%b want=11", rob_rdy_1, rob_rdy_2); end
    total++; if (commit_val_1 !== 1'b0 || commit_val_2 !== 1'b0) begin
      bad++; $display("FAIL reset_commit got=%b%b want=00", commit_val_1, commit_val_2); end
    total++; if (fill_err !== 1'b0 || alloc0_slot !== 5'd0) begin
      bad++; $display("FAIL reset_misc err=%b slot=%0d want err=0 slot=0", fill_err, alloc0_slot); end
  endtask

  task automatic test_dual_commit();
    do_reset();
    dual_alloc(5'd3, 5'd4);
    #1;
    total++; if (alloc0_slot !== 5'd0 || alloc1_slot !== 5'd1) begin
      bad++; $display("FAIL dual_slots got=%0d/%0d want=0/1", alloc0_slot, alloc1_slot); end
    step();
    set_idle(); fillB_val = 1; fillB_slot = 5'd1;
    step();
    set_idle(); fillA_val = 1; fillA_slot = 5'd0;
    #1;
    total++; if (commit_val_1 !== 1'b0) begin
      bad++; $display("FAIL dual_early got=%b want=0", commit_val_1); end
    step();
    set_idle();
    #1;
    total++; if (commit_val_1 !== 1 || commit_val_2 !== 1 || commit_slot_1 !== 0 || commit_slot_2 !== 1) begin
      bad++; $display("FAIL dual_commit got val=%b%b slots=%0d/%0d want val=11 slots=0/1",
                      commit_val_1, commit_val_2, commit_slot_1, commit_slot_2); end
    total++; if (commit_waddr_1 !== 5'd3 || commit_waddr_2 !== 5'd4 || commit_wen_1 !== 1 || commit_wen_2 !== 1) begin
      bad++; $display("FAIL dual_waddr got=%0d/%0d wen=%b%b want=3/4 wen=11",
                      commit_waddr_1, commit_waddr_2, commit_wen_1, commit_wen_2); end
    step();
    total++; if (occupancy !== 6'd0) begin bad++; $display("FAIL dual_occ got=%0d want=0", occupancy); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    dual_alloc(5'd5, 5'd6);
    step();
    set_idle(); fillA_val = 1; fillA_slot = 5'd1;
    step();
    set_idle();
    step();
    total++; if (commit_val_1 !== 1'b0 || occupancy !== 6'd2) begin
      bad++; $display("FAIL ooo_hold got val=%b occ=%0d want val=0 occ=2", commit_val_1, occupancy); end
    fillB_val = 1; fillB_slot = 5'd0;
    step();
    set_idle();
    #1;
    total++; if (commit_val_1 !== 1 || commit_val_2 !== 1 || commit_waddr_1 !== 5 || commit_waddr_2 !== 6) begin
      bad++; $display("FAIL ooo_commit got val=%b%b waddr=%0d/%0d want val=11 waddr=5/6",
                      commit_val_1, commit_val_2, commit_waddr_1, commit_waddr_2); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      dual_alloc(5'(2 * k), 5'(2 * k + 1));
      step();
    end
    set_idle();
    #1;
    total++; if (occupancy !== 6'd32 || rob_rdy_1 !== 0 || rob_rdy_2 !== 0) begin
      bad++; $display("FAIL full_state got occ=%0d rdy=%b%b want occ=32 rdy=00",
                      occupancy, rob_rdy_1, rob_rdy_2); end
    fillA_val = 1; fillA_slot = 5'd0; fillB_val = 1; fillB_slot = 5'd1;
    step();
    set_idle(); alloc1_val = 1; alloc1_wen = 1; alloc1_dst = 5'd9;
    #1;
    total++; if (commit_val_1 !== 1 || commit_val_2 !== 1) begin
      bad++; $display("FAIL full_commit got=%b%b want=11", commit_val_1, commit_val_2); end
    step();
    set_idle();
    #1;
    total++; if (occupancy !== 6'd30 || rob_rdy_2 !== 1 || rob_rdy_1 !== 1) begin
      bad++; $display("FAIL full_after got occ=%0d rdy=%b%b want occ=30 rdy=11",
                      occupancy, rob_rdy_1, rob_rdy_2); end
    total++; if (alloc0_slot !== 5'd0 || commit_val_1 !== 1'b0) begin
      bad++; $display("FAIL full_ignored got tail=%0d val=%b want tail=0 val=0", alloc0_slot, commit_val_1); end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      dual_alloc(5'(k), 5'(k));
      step();
    end
    set_idle(); alloc0_val = 1; alloc0_wen = 1;
    step();
    for (int k = 0; k < 15; k++) begin
      set_idle();
      fillA_val = 1; fillA_slot = 5'(2 * k); fillB_val = 1; fillB_slot = 5'(2 * k + 1);
      step();
    end
    set_idle(); fillA_val = 1; fillA_slot = 5'd30;
    step();
    set_idle();
    n = 0;
    while (occupancy !== 6'd0 && n < 40) begin
      step();
      n++;
    end
    total++; if (occupancy !== 6'd0 || alloc0_slot !== 5'd31) begin
      bad++; $display("FAIL wrap_drain got occ=%0d tail=%0d want occ=0 tail=31", occupancy, alloc0_slot); end
    dual_alloc(5'd10, 5'd11);
    #1;
    total++; if (alloc0_slot !== 5'd31 || alloc1_slot !== 5'd0) begin
      bad++; $display("FAIL wrap_slots got=%0d/%0d want=31/0", alloc0_slot, alloc1_slot); end
    step();
    set_idle(); fillA_val = 1; fillA_slot = 5'd31; fillB_val = 1; fillB_slot = 5'd0;
    step();
    set_idle();
    #1;
    total++; if (commit_val_1 !== 1 || commit_val_2 !== 1 || commit_slot_1 !== 31 || commit_slot_2 !== 0) begin
      bad++; $display("FAIL wrap_commit got val=%b%b slots=%0d/%0d want val=11 slots=31/0",
                      commit_val_1, commit_val_2, commit_slot_1, commit_slot_2); end
    step();
    total++; if (occupancy !== 6'd0 || alloc0_slot !== 5'd1) begin
      bad++; $display("FAIL wrap_after got occ=%0d tail=%0d want occ=0 tail=1", occupancy, alloc0_slot); end
    alloc0_val = 1; alloc0_wen = 1; alloc0_dst = 5'd2;
    step();
    set_idle(); fillA_val = 1; fillA_slot = 5'd1;
    step();
    set_idle();
    #1;
    total++; if (commit_val_1 !== 1 || commit_slot_1 !== 5'd1) begin
      bad++; $display("FAIL wrap_head got val=%b slot=%0d want val=1 slot=1", commit_val_1, commit_slot_1); end
  endtask

  task automatic test_wen0();
    do_reset();
    alloc0_val = 1; alloc0_wen = 0; alloc0_dst = 5'd9;
    step();
    set_idle(); fillA_val = 1; fillA_slot = 5'd0;
    step();
    set_idle();
    #1;
    total++; if (commit_val_1 !== 1 || commit_wen_1 !== 0 || commit_val_2 !== 0) begin
      bad++; $display("FAIL wen0 got val=%b wen=%b val2=%b want val=1 wen=0 val2=0",
                      commit_val_1, commit_wen_1, commit_val_2); end
  endtask

  task automatic test_fill_err();
    do_reset();
    fillA_val = 1; fillA_slot = 5'd5;
    step();
    set_idle();
    #1;
    total++; if (fill_err !== 1 || occupancy !== 0 || commit_val_1 !== 0) begin
      bad++; $display("FAIL err_free got err=%b occ=%0d val=%b want err=1 occ=0 val=0",
                      fill_err, occupancy, commit_val_1); end
    do_reset();
    #1;
    total++; if (fill_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", fill_err); end
    for (int k = 0; k < 4; k++) begin
      dual_alloc(5'(k), 5'(k));
      step();
    end
    for (int k = 0; k < 3; k++) begin
      set_idle();
      fillA_val = 1; fillA_slot = 5'(2 * k); fillB_val = 1; fillB_slot = 5'(2 * k + 1);
      step();
    end
    set_idle(); fillA_val = 1; fillA_slot = 5'd6;
    step();
    set_idle(); fillA_val = 1; fillA_slot = 5'd7; fillB_val = 1; fillB_slot = 5'd7;
    step();
    set_idle();
    step(); step(); step();
    total++; if (fill_err !== 1 || occupancy !== 6'd1 || commit_val_1 !== 0) begin
      bad++; $display("FAIL err_collide got err=%b occ=%0d val=%b want err=1 occ=1 val=0",
                      fill_err, occupancy, commit_val_1); end
    fillA_val = 1; fillA_slot = 5'd7;
    step();
    set_idle();
    #1;
    total++; if (commit_val_1 !== 1 || commit_slot_1 !== 5'd7 || fill_err !== 1) begin
      bad++; $display("FAIL err_recover got val=%b slot=%0d err=%b want val=1 slot=7 err=1",
                      commit_val_1, commit_slot_1, fill_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dual_commit();
    test_out_of_order();
    test_full();
    test_wrap();
    test_wen0();
    test_fill_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
